// File: rtl/text_pkg.sv
// text_pkg: shared character codes, updater states and decimal helpers for the text path
package text_pkg;

    localparam logic [6:0] CHAR_SPACE = 7'h20;
    localparam logic [6:0] CHAR_ZERO  = 7'h30;

    typedef enum logic [1:0] {IDLE, CONVERT, WRITE, DONE} txt_upd_state_t;

    // largest value representable with n decimal digits
    function automatic longint dec_max(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r - 1;
    endfunction

endpackage

// File: rtl/score_text_updater_bin2bcd.sv
// bin2bcd_seq: serial shift-add-3 binary to BCD converter, one input bit per step
module bin2bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BIN_W-1:0]      din,
    input  logic                  step,
    output logic [4*DIGITS-1:0]   bcd_out
);

    logic [BIN_W-1:0]    r_bin;
    logic [4*DIGITS-1:0] r_bcd;
    logic [4*DIGITS-1:0] w_adj;

    // pre-correct every nibble that would overflow past 9 after the next doubling
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++)
            if (r_bcd[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end

    // load clears the BCD side; each step shifts the next binary MSB into the BCD LSB
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin <= '0;
            r_bcd <= '0;
        end else if (load) begin
            r_bin <= din;
            r_bcd <= '0;
        end else if (step) begin
            {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
        end
    end

    assign bcd_out = r_bcd;

endmodule

// File: rtl/score_text_updater.sv
// score_text_updater: converts a binary score to ASCII digits and writes them into the char buffer
module score_text_updater
    import text_pkg::*;
#(
    parameter int SCORE_W    = 14,
    parameter int NUM_DIGITS = 4,
    parameter int ADDR_W     = 7,
    parameter int BASE_ADDR  = 0,
    parameter int BLANK_LZ   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SCORE_W-1:0] value,
    output logic               busy,
    output logic               done,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [6:0]         wr_data
);

    localparam int     CNT_W   = SCORE_W > 1 ? $clog2(SCORE_W) : 1;
    localparam int     IDX_W   = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam longint MAX_VAL = dec_max(NUM_DIGITS);

    txt_upd_state_t        r_state, w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_lz;
    logic                  r_pend;
    logic [SCORE_W-1:0]    r_pval;
    logic                  w_load;
    logic [SCORE_W-1:0]    w_req;
    logic [SCORE_W-1:0]    w_sat;
    logic [4*NUM_DIGITS-1:0] w_bcd;
    logic [3:0]            w_digit;
    logic                  w_blank;

    // a fresh start always wins over an older queued value
    assign w_req = start ? value : r_pval;
    assign w_sat = (64'(w_req) > 64'(MAX_VAL)) ? SCORE_W'(MAX_VAL) : w_req;

    bin2bcd_seq #(.BIN_W(SCORE_W), .DIGITS(NUM_DIGITS)) u_bcd (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .din     (w_sat),
        .step    (r_state == CONVERT),
        .bcd_out (w_bcd)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next state; DONE chains straight into CONVERT when a request is waiting
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            IDLE:    if (start) begin w_next = CONVERT; w_load = 1'b1; end
            CONVERT: if (r_cnt == '0) w_next = WRITE;
            WRITE:   if (r_idx == IDX_W'(NUM_DIGITS-1)) w_next = DONE;
            DONE:    if (start || r_pend) begin w_next = CONVERT; w_load = 1'b1; end
                     else w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // bit counter, digit index, leading-zero tracker and the pending request latch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_lz   <= 1'b0;
            r_pend <= 1'b0;
            r_pval <= '0;
        end else begin
            if (w_load) r_cnt <= CNT_W'(SCORE_W-1);
            else if (r_state == CONVERT) r_cnt <= r_cnt - 1'b1;
            r_idx <= (r_state == WRITE) ? r_idx + 1'b1 : '0;
            if (r_state != WRITE) r_lz <= 1'b1;
            else if (w_digit != 4'd0) r_lz <= 1'b0;
            if (w_load) r_pend <= 1'b0;
            else if (start && r_state != IDLE) r_pend <= 1'b1;
            if (start && r_state != IDLE) r_pval <= value;
        end
    end

    assign w_digit = 4'(w_bcd >> (4*(NUM_DIGITS-1-int'(r_idx))));
    assign w_blank = (BLANK_LZ != 0) && r_lz && (w_digit == 4'd0) && (r_idx != IDX_W'(NUM_DIGITS-1));

    assign busy    = r_state != IDLE;
    assign done    = r_state == DONE;
    assign wr_en   = r_state == WRITE;
    assign wr_addr = wr_en ? ADDR_W'(BASE_ADDR) + ADDR_W'(r_idx) : '0;
    assign wr_data = wr_en ? (w_blank ? CHAR_SPACE : CHAR_ZERO + {3'b000, w_digit}) : '0;

endmodule

// File: tb/tb_score_text_updater.sv
// tb_score_text_updater: table, directed and random checks of the score text sequencer
module tb_score_text_updater;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        clr = 1'b0;
    logic [13:0] value = '0;
    logic        a_busy, a_done, a_wr_en;
    logic        b_busy, b_done, b_wr_en;
    logic        c_busy, c_done, c_wr_en;
    logic [6:0]  a_wr_addr, a_wr_data, b_wr_addr, b_wr_data, c_wr_addr, c_wr_data;
    logic [6:0]  mem_a [128];
    logic [6:0]  mem_b [128];
    logic [6:0]  mem_c [128];
    int          wr_a, done_a;
    int          n_vec = 0;
    int          n_bad = 0;

    typedef struct {
        int          val;
        logic [27:0] ea;
        logic [27:0] eb;
    } vec_t;
    vec_t tbl [10];

    always #5 clk = ~clk;

    score_text_updater dut_a (
        .clk(clk), .rst(rst), .start(start), .value(value), .busy(a_busy), .done(a_done),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data));

    score_text_updater #(.BLANK_LZ(0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .value(value), .busy(b_busy), .done(b_done),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data));

    score_text_updater #(.BASE_ADDR(126)) dut_c (
        .clk(clk), .rst(rst), .start(start), .value(value), .busy(c_busy), .done(c_done),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data));

    // char buffer models with a 1-cycle synchronous write, plus write/done counters
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 128; i++) begin
                mem_a[i] <= 7'h7f;
                mem_b[i] <= 7'h7f;
                mem_c[i] <= 7'h7f;
            end
            wr_a   <= 0;
            done_a <= 0;
        end else begin
            if (a_wr_en) begin mem_a[a_wr_addr] <= a_wr_data; wr_a <= wr_a + 1; end
            if (b_wr_en) mem_b[b_wr_addr] <= b_wr_data;
            if (c_wr_en) mem_c[c_wr_addr] <= c_wr_data;
            if (a_done) done_a <= done_a + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear;
        clr = 1'b1;
        tick;
        clr = 1'b0;
    endtask

    // reference: saturate, split into decimal digits, blank leading zeros except the last
    function automatic logic [27:0] model(input int v, input bit blank);
        int          s;
        int          p;
        bit          lead;
        logic [27:0] r;
        s    = v > 9999 ? 9999 : v;
        p    = 1000;
        lead = blank;
        r    = '0;
        for (int i = 0; i < 4; i++) begin
            int d;
            d = (s / p) % 10;
            if (lead && d == 0 && i < 3) r[27-7*i -: 7] = 7'h20;
            else begin
                r[27-7*i -: 7] = 7'(48 + d);
                lead = 1'b0;
            end
            p = p / 10;
        end
        return r;
    endfunction

    function automatic logic [27:0] str_a();
        return {mem_a[0], mem_a[1], mem_a[2], mem_a[3]};
    endfunction

    function automatic logic [27:0] str_b();
        return {mem_b[0], mem_b[1], mem_b[2], mem_b[3]};
    endfunction

    function automatic logic [27:0] str_c();
        return {mem_c[126], mem_c[127], mem_c[0], mem_c[1]};
    endfunction

    // one isolated request with cycle-exact timing checks on all three instances
    task automatic do_single(input int v, input logic [27:0] ea, input logic [27:0] eb);
        clear;
        start = 1'b1;
        value = 14'(v);
        tick;
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            chk("busy_a", a_busy, k <= 19);
            chk("done_a", a_done, k == 19);
            chk("wr_en_a", a_wr_en, k >= 15 && k <= 18);
            chk("busy_b", b_busy, k <= 19);
            chk("done_c", c_done, k == 19);
            chk("wr_en_c", c_wr_en, k >= 15 && k <= 18);
            if (k >= 15 && k <= 18) begin
                chk("addr_a", a_wr_addr, k - 15);
                chk("addr_c", c_wr_addr, (126 + k - 15) % 128);
            end
            if (k < 20) tick;
        end
        chk("str_a", str_a(), ea);
        chk("str_b", str_b(), eb);
        chk("str_c", str_c(), ea);
        chk("mem_c_untouched", mem_c[2], 7'h7f);
        chk("writes_a", wr_a, 4);
        chk("dones_a", done_a, 1);
    endtask

    // first request plus up to two more starts at cycle offsets k2/k3; last one must be written second
    task automatic run_pair(input int v1, input int k2, input int v2, input int k3, input int v3,
                            input logic [27:0] e1, input logic [27:0] e2);
        clear;
        start = 1'b1;
        value = 14'(v1);
        tick;
        start = 1'b0;
        for (int k = 1; k <= 39; k++) begin
            chk("pair_busy", a_busy, k <= 38);
            chk("pair_done", a_done, k == 19 || k == 38);
            chk("pair_wr_en", a_wr_en, (k >= 15 && k <= 18) || (k >= 34 && k <= 37));
            if (k >= 34 && k <= 37) chk("pair_addr", a_wr_addr, k - 34);
            if (k == 19) chk("pair_first_str", str_a(), e1);
            start = (k == k2) || (k == k3);
            value = (k == k2) ? 14'(v2) : 14'(v3);
            tick;
        end
        start = 1'b0;
        chk("pair_second_str", str_a(), e2);
        chk("pair_writes", wr_a, 8);
        chk("pair_dones", done_a, 2);
    endtask

    initial begin
        tbl[0] = '{1234,  {7'h31, 7'h32, 7'h33, 7'h34}, {7'h31, 7'h32, 7'h33, 7'h34}};
        tbl[1] = '{7,     {7'h20, 7'h20, 7'h20, 7'h37}, {7'h30, 7'h30, 7'h30, 7'h37}};
        tbl[2] = '{0,     {7'h20, 7'h20, 7'h20, 7'h30}, {7'h30, 7'h30, 7'h30, 7'h30}};
        tbl[3] = '{12000, {7'h39, 7'h39, 7'h39, 7'h39}, {7'h39, 7'h39, 7'h39, 7'h39}};
        tbl[4] = '{9999,  {7'h39, 7'h39, 7'h39, 7'h39}, {7'h39, 7'h39, 7'h39, 7'h39}};
        tbl[5] = '{10000, {7'h39, 7'h39, 7'h39, 7'h39}, {7'h39, 7'h39, 7'h39, 7'h39}};
        tbl[6] = '{100,   {7'h20, 7'h31, 7'h30, 7'h30}, {7'h30, 7'h31, 7'h30, 7'h30}};
        tbl[7] = '{1000,  {7'h31, 7'h30, 7'h30, 7'h30}, {7'h31, 7'h30, 7'h30, 7'h30}};
        tbl[8] = '{60,    {7'h20, 7'h20, 7'h36, 7'h30}, {7'h30, 7'h30, 7'h36, 7'h30}};
        tbl[9] = '{16383, {7'h39, 7'h39, 7'h39, 7'h39}, {7'h39, 7'h39, 7'h39, 7'h39}};

        clr = 1'b1;
        tick;
        tick;
        clr = 1'b0;
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_wr_en", a_wr_en, 0);
        chk("rst_wr_addr", a_wr_addr, 0);
        chk("rst_wr_data", a_wr_data, 0);
        chk("rst_busy_c", c_busy, 0);
        rst = 1'b0;
        tick;
        chk("idle_busy", a_busy, 0);

        for (int i = 0; i < 10; i++) do_single(tbl[i].val, tbl[i].ea, tbl[i].eb);

        run_pair(5, 3, 42, 10, 88, {7'h20, 7'h20, 7'h20, 7'h35}, {7'h20, 7'h20, 7'h38, 7'h38});
        run_pair(9, 19, 321, 0, 0, {7'h20, 7'h20, 7'h20, 7'h39}, {7'h20, 7'h33, 7'h32, 7'h31});

        // reset in the middle of the write burst with a request queued
        clear;
        start = 1'b1;
        value = 14'd1234;
        tick;
        start = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            chk("rst_seq_busy", a_busy, k <= 16);
            chk("rst_seq_wr_en", a_wr_en, k == 15 || k == 16);
            chk("rst_seq_done", a_done, 0);
            if (k >= 17) begin
                chk("rst_seq_addr", a_wr_addr, 0);
                chk("rst_seq_data", a_wr_data, 0);
            end
            start = (k == 5);
            value = 14'd77;
            rst   = (k == 16 || k == 17);
            tick;
        end
        start = 1'b0;
        rst   = 1'b0;
        chk("rst_seq_writes", wr_a, 2);
        chk("rst_seq_dones", done_a, 0);

        for (int i = 0; i < 16; i++) begin
            int v;
            v = (i % 2 == 1) ? int'($urandom_range(0, 120)) : int'($urandom_range(0, 16383));
            do_single(v, model(v, 1'b1), model(v, 1'b0));
        end

        for (int i = 0; i < 5; i++) begin
            int v1, v2, k2;
            v1 = int'($urandom_range(0, 16383));
            v2 = int'($urandom_range(0, 16383));
            k2 = int'($urandom_range(1, 19));
            run_pair(v1, k2, v2, 0, 0, model(v1, 1'b1), model(v2, 1'b1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
